// File: rtl/pps_if.sv
// Control and status bundle of the PPS timebase: trim handshake, alignment,
// seconds preload and the pulse/counter outputs.
interface pps_if #(
    parameter int unsigned CNT_W = 32
);
    logic             en;
    logic             sync;
    logic             adj_valid;
    logic [15:0]      adj;
    logic             adj_ready;
    logic             sec_load;
    logic [31:0]      sec_val;
    logic             pps;
    logic             pps_stb;
    logic [CNT_W-1:0] sub_cnt;
    logic [31:0]      sec_cnt;

    modport master (
        output en, sync, adj_valid, adj, sec_load, sec_val,
        input  adj_ready, pps, pps_stb, sub_cnt, sec_cnt
    );

    modport slave (
        input  en, sync, adj_valid, adj, sec_load, sec_val,
        output adj_ready, pps, pps_stb, sub_cnt, sec_cnt
    );
endinterface

// File: rtl/pps_gen.sv
// Free-running one-pulse-per-second timebase with per-second trim, external
// alignment strobe and seconds preload. All outputs are registered.
module pps_gen #(
    parameter int unsigned PERIOD    = 100_000_000,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned PULSE_LEN = 10_000_000
) (
    input  logic  clk,
    input  logic  rst,
    pps_if.slave  bus
);
    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [CNT_W-1:0] TermNom   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] PulseLoad = CNT_W'(PULSE_LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] sub_cnt_q, sub_cnt_d;
    logic [CNT_W-1:0] term_q, term_d;
    logic [CNT_W-1:0] pulse_q, pulse_d;
    logic [31:0]      sec_cnt_q, sec_cnt_d;
    logic             pps_q, pps_d;
    logic             pps_stb_q, pps_stb_d;
    logic             adj_ready_q, adj_ready_d;
    logic [15:0]      pend_adj_q, pend_adj_d;
    logic             accept, rollover, restart;
    logic [15:0]      trim;

    always_comb begin
        state_d     = state_q;
        sub_cnt_d   = sub_cnt_q;
        term_d      = term_q;
        pulse_d     = pulse_q;
        sec_cnt_d   = sec_cnt_q;
        pps_d       = pps_q;
        pps_stb_d   = 1'b0;
        adj_ready_d = adj_ready_q;
        pend_adj_d  = pend_adj_q;
        rollover    = 1'b0;
        restart     = 1'b0;
        trim        = '0;
        accept      = bus.adj_valid & adj_ready_q;

        // adj_ready low means a trim is pending.
        if (accept) begin
            adj_ready_d = 1'b0;
            pend_adj_d  = bus.adj;
        end

        if (pps_q) begin
            if (pulse_q == '0) begin
                pps_d = 1'b0;
            end else begin
                pulse_d = pulse_q - CNT_W'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.en) begin
                    state_d = StRun;
                    restart = 1'b1;
                    term_d  = TermNom;
                end
            end
            StRun: begin
                if (!bus.en) begin
                    state_d   = StIdle;
                    sub_cnt_d = '0;
                    pps_d     = 1'b0;
                end else if (sub_cnt_q == term_q || bus.sync) begin
                    rollover  = 1'b1;
                    restart   = 1'b1;
                    sec_cnt_d = sec_cnt_q + 32'd1;
                end else begin
                    sub_cnt_d = sub_cnt_q + CNT_W'(1);
                end
            end
        endcase

        if (restart) begin
            sub_cnt_d = '0;
            pps_d     = 1'b1;
            pps_stb_d = 1'b1;
            pulse_d   = PulseLoad;
        end

        // A trim accepted on the rollover cycle is consumed directly.
        if (rollover) begin
            if (accept) begin
                trim        = bus.adj;
                adj_ready_d = 1'b1;
            end else if (!adj_ready_q) begin
                trim        = pend_adj_q;
                adj_ready_d = 1'b1;
            end
            // Low CNT_W bits of the CNT_W+1 signed sum.
            term_d = TermNom + {{(CNT_W - 16){trim[15]}}, trim};
        end

        if (bus.sec_load) begin
            sec_cnt_d = bus.sec_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            sub_cnt_q   <= '0;
            term_q      <= TermNom;
            pulse_q     <= '0;
            sec_cnt_q   <= '0;
            pps_q       <= 1'b0;
            pps_stb_q   <= 1'b0;
            adj_ready_q <= 1'b1;
            pend_adj_q  <= '0;
        end else begin
            state_q     <= state_d;
            sub_cnt_q   <= sub_cnt_d;
            term_q      <= term_d;
            pulse_q     <= pulse_d;
            sec_cnt_q   <= sec_cnt_d;
            pps_q       <= pps_d;
            pps_stb_q   <= pps_stb_d;
            adj_ready_q <= adj_ready_d;
            pend_adj_q  <= pend_adj_d;
        end
    end

    assign bus.sub_cnt   = sub_cnt_q;
    assign bus.sec_cnt   = sec_cnt_q;
    assign bus.pps       = pps_q;
    assign bus.pps_stb   = pps_stb_q;
    assign bus.adj_ready = adj_ready_q;
endmodule

// File: tb/tb_pps_gen.sv
// Bench for pps_gen: directed second-length/strobe scenarios plus random
// stimulus, all checked against a second-level behavioural model.
module tb_pps_gen;
    localparam int PERIOD    = 100;
    localparam int PULSE_LEN = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   r_len, r_pps, r_rdylo;
    logic [31:0] s0;

    pps_if #(.CNT_W(32)) bus ();

    pps_gen #(.PERIOD(PERIOD), .CNT_W(32), .PULSE_LEN(PULSE_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state: position within the current second and that second's length.
    typedef struct {
        bit          run;
        int          sub;
        int          len;
        logic [31:0] sec;
        bit          pend;
        int          padj;
        bit          stb;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t step(input mdl_t c, input bit en, input bit sync, input bit av,
                                  input int adj, input bit ld, input logic [31:0] lv);
        mdl_t n;
        bit   acc;
        n     = c;
        n.stb = 1'b0;
        acc   = av && !c.pend;
        if (!c.run) begin
            if (en) begin
                n.run = 1'b1;
                n.sub = 0;
                n.len = PERIOD;
                n.stb = 1'b1;
            end
            if (acc) begin
                n.pend = 1'b1;
                n.padj = adj;
            end
        end else if (!en) begin
            n.run = 1'b0;
            n.sub = 0;
            if (acc) begin
                n.pend = 1'b1;
                n.padj = adj;
            end
        end else if (c.sub == c.len - 1 || sync) begin
            n.sub  = 0;
            n.sec  = c.sec + 32'd1;
            n.stb  = 1'b1;
            n.len  = PERIOD + (acc ? adj : (c.pend ? c.padj : 0));
            n.pend = 1'b0;
        end else begin
            n.sub = c.sub + 1;
            if (acc) begin
                n.pend = 1'b1;
                n.padj = adj;
            end
        end
        if (ld) n.sec = lv;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= '{run: 1'b0, sub: 0, len: PERIOD, sec: 32'd0, pend: 1'b0, padj: 0, stb: 1'b0};
        end else begin
            m <= step(m, bus.en, bus.sync, bus.adj_valid, int'($signed(bus.adj)), bus.sec_load,
                      bus.sec_val);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("mdl_sub_cnt", 64'(bus.sub_cnt), 64'(m.sub));
            chk("mdl_sec_cnt", 64'(bus.sec_cnt), 64'(m.sec));
            chk("mdl_pps", 64'(bus.pps), 64'(m.run && m.sub < PULSE_LEN));
            chk("mdl_pps_stb", 64'(bus.pps_stb), 64'(m.stb));
            chk("mdl_adj_ready", 64'(bus.adj_ready), 64'(!m.pend));
        end
    end

    // Entered at the negedge of a strobe cycle; runs to the next strobe.
    // kind: 1 trim, 2 sync, 3 seconds load, applied in the cycle with sub_cnt == act_at.
    task automatic second(input int act_at, input int kind, input logic [31:0] val);
        r_len   = 0;
        r_pps   = int'(bus.pps);
        r_rdylo = int'(!bus.adj_ready);
        for (int i = 0; i < 300; i++) begin
            if (i == act_at) begin
                case (kind)
                    1: begin bus.adj_valid = 1'b1; bus.adj = val[15:0]; end
                    2: bus.sync = 1'b1;
                    3: begin bus.sec_load = 1'b1; bus.sec_val = val; end
                    default: ;
                endcase
            end
            @(negedge clk);
            bus.adj_valid = 1'b0;
            bus.sync      = 1'b0;
            bus.sec_load  = 1'b0;
            if (bus.pps_stb) begin
                r_len = i + 1;
                break;
            end
            r_pps   += int'(bus.pps);
            r_rdylo += int'(!bus.adj_ready);
        end
        if (r_len == 0) begin
            total++;
            bad++;
            $display("FAIL second_timeout: got no pps_stb want one within 300 cycles");
        end
    endtask

    initial begin
        bus.en = 1'b0; bus.sync = 1'b0; bus.adj_valid = 1'b0; bus.adj = '0;
        bus.sec_load = 1'b0; bus.sec_val = '0;

        repeat (5) @(negedge clk);
        chk("rst_sub_cnt", 64'(bus.sub_cnt), 64'd0);
        chk("rst_pps", 64'(bus.pps), 64'd0);
        chk("rst_adj_ready", 64'(bus.adj_ready), 64'd1);
        rst    = 1'b0;
        bus.en = 1'b1;
        @(negedge clk);
        chk("entry_stb", 64'(bus.pps_stb), 64'd1);
        chk("entry_sec", 64'(bus.sec_cnt), 64'd0);

        second(-1, 0, 0);
        chk("len_nom", 64'(r_len), 64'd100);
        chk("pps_width", 64'(r_pps), 64'd10);
        second(-1, 0, 0);
        second(-1, 0, 0);
        chk("sec_three", 64'(bus.sec_cnt), 64'd3);

        second(30, 1, 32'd5);
        chk("len_pre_trim", 64'(r_len), 64'd100);
        chk("rdy_low_span", 64'(r_rdylo), 64'd69);
        second(-1, 0, 0);
        chk("len_trim_p5", 64'(r_len), 64'd105);
        chk("rdy_back", 64'(r_rdylo), 64'd0);
        second(-1, 0, 0);
        chk("len_revert", 64'(r_len), 64'd100);
        second(50, 1, 32'hFFFF_FFFD);
        second(-1, 0, 0);
        chk("len_trim_m3", 64'(r_len), 64'd97);

        second(99, 1, 32'd7);
        chk("rdy_same_cyc", 64'(r_rdylo), 64'd0);
        second(-1, 0, 0);
        chk("len_trim_p7", 64'(r_len), 64'd107);
        chk("rdy_never_low", 64'(r_rdylo), 64'd0);

        s0 = bus.sec_cnt;
        second(40, 2, 0);
        chk("len_sync40", 64'(r_len), 64'd41);
        chk("sec_sync40", 64'(bus.sec_cnt), 64'(s0 + 32'd1));
        second(-1, 0, 0);
        chk("len_after_sync", 64'(r_len), 64'd100);
        s0 = bus.sec_cnt;
        second(99, 2, 0);
        chk("len_sync99", 64'(r_len), 64'd100);
        chk("sec_sync99", 64'(bus.sec_cnt), 64'(s0 + 32'd1));

        second(99, 3, 32'hFFFF_FFFE);
        chk("sec_load_wins", 64'(bus.sec_cnt), 64'hFFFF_FFFE);
        second(-1, 0, 0);
        chk("sec_max", 64'(bus.sec_cnt), 64'hFFFF_FFFF);
        second(-1, 0, 0);
        chk("sec_wrap", 64'(bus.sec_cnt), 64'd0);
        second(-1, 0, 0);

        repeat (4) @(negedge clk);
        chk("pre_rst_pps", 64'(bus.pps), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_sub_cnt", 64'(bus.sub_cnt), 64'd0);
        chk("arst_sec_cnt", 64'(bus.sec_cnt), 64'd0);
        chk("arst_pps", 64'(bus.pps), 64'd0);
        chk("arst_pps_stb", 64'(bus.pps_stb), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        second(-1, 0, 0);
        repeat (20) @(negedge clk);
        s0     = bus.sec_cnt;
        bus.en = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_pps", 64'(bus.pps), 64'd0);
        chk("idle_sub_cnt", 64'(bus.sub_cnt), 64'd0);
        chk("idle_sec_kept", 64'(bus.sec_cnt), 64'(s0));
        bus.en = 1'b1;
        @(negedge clk);
        chk("reentry_stb", 64'(bus.pps_stb), 64'd1);

        for (int c = 0; c < 4000; c++) begin
            bus.en        = ($urandom_range(0, 149) != 0);
            bus.sync      = ($urandom_range(0, 149) == 0);
            bus.adj_valid = ($urandom_range(0, 19) == 0);
            bus.adj       = 16'(int'($urandom_range(0, 40)) - 20);
            bus.sec_load  = ($urandom_range(0, 299) == 0);
            bus.sec_val   = $urandom;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
